// File: rtl/button_event_arbiter_pkg.sv
// Shared definitions for the button event arbiter: FSM encodings and drop counter width.
package button_event_arbiter_pkg;

  localparam logic [0:0] ARB_IDLE    = 1'b0;
  localparam logic [0:0] ARB_PRESENT = 1'b1;

  localparam int unsigned DROP_CNT_W = 8;

endpackage

// File: rtl/button_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning from ptr upward, wrapping.
module rr_pick #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  int unsigned pos;

  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = (32'(ptr) + k) % N_REQ;
      if (!any && req[ID_W'(pos)]) begin
        any = 1'b1;
        idx = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Latches event pulses and presents them one at a time over valid/ready with round-robin fairness.
// Optional saturating lost-event counter enabled by defining EVT_DROP_CNT_EN.
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      pulse_in,
  input  logic [N_REQ-1:0]      en_mask,
  output logic                  out_valid,
  output logic [ID_W-1:0]       out_id,
  input  logic                  out_ready,
`ifdef EVT_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0] drop_cnt,
  input  logic                  drop_clr,
`endif
  output logic [N_REQ-1:0]      pending
);

  logic [0:0]       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_d;
  logic [N_REQ-1:0] pending_d;
  logic [N_REQ-1:0] grant;
  logic             take;
  logic             win_any;
  logic [ID_W-1:0]  win_idx;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (pending),
    .ptr (rr_ptr),
    .any (win_any),
    .idx (win_idx)
  );

  // Next state and grant decision; at most one grant per cycle.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    grant   = '0;
    case (state_q)
      ARB_IDLE: begin
        if (win_any) begin
          take    = 1'b1;
          state_d = ARB_PRESENT;
        end
      end
      ARB_PRESENT: begin
        if (out_ready) begin
          if (win_any) take = 1'b1;
          else         state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (take) grant = N_REQ'(1) << win_idx;
  end

  // A new pulse beats a same-cycle grant clear, so the fresh event stays pending.
  assign pending_d = ((pending & ~grant) | pulse_in) & en_mask;
  assign rr_ptr_d  = !take ? rr_ptr :
                     (32'(win_idx) == N_REQ - 1) ? '0 : win_idx + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      pending   <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
    end else begin
      state_q   <= state_d;
      pending   <= pending_d;
      rr_ptr    <= rr_ptr_d;
      out_valid <= (state_d == ARB_PRESENT);
      if (take) out_id <= win_idx;
    end
  end

`ifdef EVT_DROP_CNT_EN
  logic any_drop_c;
  assign any_drop_c = |(pulse_in & en_mask & pending & ~grant);

  // Counts cycles with at least one lost event; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     drop_cnt <= '0;
    else if (drop_clr)                              drop_cnt <= '0;
    else if (any_drop_c && (drop_cnt != '1))        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
  end
`endif

endmodule
